// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the four-way packet-aware round-robin arbiter:
// state encoding, requester count and the round-robin scan helpers.
package mux4_arb_pkg;

   localparam int unsigned N_REQ = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } st_e;

   // k-th candidate in the scan that starts just after the last owner:
   // k=0 -> ptr+1, k=1 -> ptr+2, k=2 -> ptr+3, k=3 -> ptr (all modulo 4).
   function automatic logic [1:0] rr_slot(input logic [1:0] ptr, input logic [1:0] k);
      return ptr + 2'd1 + k;
   endfunction

   // One-hot grant vector for a requester index.
   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: returns the first unmasked requester,
// scanning from the slot after ptr and wrapping back around to ptr itself.
module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [3:0] req,
   input  logic [3:0] mask,
   input  logic [1:0] ptr,
   output logic       any,
   output logic [1:0] idx
);

   logic [3:0] eff_s;

   assign eff_s = req & ~mask;

   // Walk the scan order once; the first eligible slot wins.
   always_comb begin
      logic       found_v;
      logic [1:0] cand_v;
      logic [1:0] idx_v;
      found_v = 1'b0;
      idx_v   = 2'd0;
      cand_v  = 2'd0;
      for (int k = 0; k < int'(N_REQ); k++) begin
         cand_v = rr_slot(ptr, 2'(k));
         if (!found_v && eff_s[cand_v]) begin
            found_v = 1'b1;
            idx_v   = cand_v;
         end else begin
            found_v = found_v;
         end
      end
      any = found_v;
      idx = idx_v;
   end

endmodule

// File: rtl/mux4_arb.sv
// Four-requester packet-aware round-robin arbiter driving a 4:1 data mux.
// A grant is held from the first beat through the beat flagged last; an
// idle watchdog reclaims the channel from an owner that stops requesting.
module mux4_arb
   import mux4_arb_pkg::*;
#(
   parameter int unsigned w = 4,
   parameter int unsigned t = 8
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   req,
   input  logic [3:0]   last,
   input  logic [w-1:0] d0,
   input  logic [w-1:0] d1,
   input  logic [w-1:0] d2,
   input  logic [w-1:0] d3,
   input  logic         o_ready,
   output logic         o_valid,
   output logic [w-1:0] o,
   output logic         o_last,
   output logic [3:0]   ack,
   output logic [3:0]   gnt,
   output logic [1:0]   s
);

   st_e         st_q, st_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [1:0]  s_q, s_d;
   logic [3:0]  gnt_q, gnt_d;
   logic [7:0]  cnt_q, cnt_d;

   logic [1:0]   pick_ptr_s;
   logic [3:0]   pick_mask_s;
   logic         pick_any_s;
   logic [1:0]   pick_idx_s;
   logic [w-1:0] data_s;
   logic         xfer_s;
   logic         fin_s;
   logic         wd_s;
   logic         rel_s;

   assign gnt = gnt_q;
   assign s   = s_q;

   // Picker inputs: IDLE scans from the last owner; BUSY re-picks from the
   // current owner with its own request masked so rotation always moves on.
   always_comb begin
      if (st_q == ST_BUSY) begin
         pick_ptr_s  = s_q;
         pick_mask_s = onehot4(s_q);
      end else begin
         pick_ptr_s  = ptr_q;
         pick_mask_s = 4'b0000;
      end
   end

   rr_pick4 u_pick (
      .req  (req),
      .mask (pick_mask_s),
      .ptr  (pick_ptr_s),
      .any  (pick_any_s),
      .idx  (pick_idx_s)
   );

   // 4:1 data select on the registered grant index.
   always_comb begin
      case (s_q)
         2'd0:    data_s = d0;
         2'd1:    data_s = d1;
         2'd2:    data_s = d2;
         2'd3:    data_s = d3;
         default: data_s = {w{1'b0}};
      endcase
   end

   // Release conditions: final beat of a packet, or owner idle for t cycles.
   always_comb begin
      xfer_s = req[s_q] & o_ready;
      fin_s  = xfer_s & last[s_q];
      wd_s   = ~req[s_q] & (cnt_q == 8'(t - 1));
      rel_s  = fin_s | wd_s;
   end

   // Channel outputs; forced quiet in IDLE and while reset is asserted so a
   // mid-packet reset never acknowledges a beat.
   always_comb begin
      o_valid = 1'b0;
      o       = {w{1'b0}};
      o_last  = 1'b0;
      ack     = 4'b0000;
      if (rst_n && (st_q == ST_BUSY)) begin
         o_valid = req[s_q];
         o       = data_s;
         o_last  = last[s_q] & req[s_q];
         ack     = onehot4(s_q) & {4{xfer_s}};
      end else begin
         o_valid = 1'b0;
      end
   end

   // Next-state logic for the grant FSM, owner pointer and watchdog counter.
   always_comb begin
      st_d  = st_q;
      ptr_d = ptr_q;
      s_d   = s_q;
      gnt_d = gnt_q;
      cnt_d = cnt_q;
      case (st_q)
         ST_IDLE: begin
            if (pick_any_s) begin
               s_d   = pick_idx_s;
               gnt_d = onehot4(pick_idx_s);
               cnt_d = 8'd0;
               st_d  = ST_BUSY;
            end else begin
               st_d  = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (rel_s) begin
               ptr_d = s_q;
               cnt_d = 8'd0;
               if (pick_any_s) begin
                  // Back-to-back hand-over: no idle bubble.
                  s_d   = pick_idx_s;
                  gnt_d = onehot4(pick_idx_s);
                  st_d  = ST_BUSY;
               end else begin
                  gnt_d = 4'b0000;
                  st_d  = ST_IDLE;
               end
            end else if (xfer_s) begin
               cnt_d = 8'd0;
            end else if (!req[s_q]) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               // Backpressure: owner still requesting, hold grant and count.
               cnt_d = cnt_q;
            end
         end
         default: begin
            st_d  = ST_IDLE;
            gnt_d = 4'b0000;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q  <= ST_IDLE;
         ptr_q <= 2'd3;
         s_q   <= 2'd0;
         gnt_q <= 4'b0000;
         cnt_q <= 8'd0;
      end else begin
         st_q  <= st_d;
         ptr_q <= ptr_d;
         s_q   <= s_d;
         gnt_q <= gnt_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mux4_arb.sv
// Directed self-checking bench for mux4_arb (w=4, t=8).
module tb_mux4_arb;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] last;
   logic [3:0] d0, d1, d2, d3;
   logic       o_ready;
   logic       o_valid;
   logic [3:0] o;
   logic       o_last;
   logic [3:0] ack;
   logic [3:0] gnt;
   logic [1:0] s;

   int errors = 0;
   int checks = 0;

   mux4_arb #(.w(4), .t(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .last    (last),
      .d0      (d0),
      .d1      (d1),
      .d2      (d2),
      .d3      (d3),
      .o_ready (o_ready),
      .o_valid (o_valid),
      .o       (o),
      .o_last  (o_last),
      .ack     (ack),
      .gnt     (gnt),
      .s       (s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      last  = 4'b0000;
      o_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   logic [3:0] dval [4];

   initial begin
      dval[0] = 4'hA; dval[1] = 4'hB; dval[2] = 4'hC; dval[3] = 4'hD;
      d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
      rst_n = 1'b0; req = 4'b0000; last = 4'b0000; o_ready = 1'b0;

      // ---- reset state ----
      tick(); tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_s", 32'(s), 32'h0);
      chk("rst_ovalid", 32'(o_valid), 32'h0);
      chk("rst_o", 32'(o), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);

      // ---- first pick after reset, single-beat packets from everyone ----
      rst_n = 1'b1; req = 4'b1111; last = 4'b1111; o_ready = 1'b1;
      #1;
      chk("rr_idle_ack", 32'(ack), 32'h0);
      chk("rr_idle_ovalid", 32'(o_valid), 32'h0);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
         chk("rr_s", 32'(s), 32'(i % 4));
         chk("rr_o", 32'(o), 32'(dval[i % 4]));
         chk("rr_ack", 32'(ack), 32'(4'b0001 << (i % 4)));
         chk("rr_olast", 32'(o_last), 32'h1);
         tick();
      end

      // ---- packet hold: owner 2 sends 3 beats while req[0] waits ----
      do_reset();
      req = 4'b0100; last = 4'b0000; o_ready = 1'b1;
      tick();
      req = 4'b0101;
      for (int b = 0; b < 3; b++) begin
         last = (b == 2) ? 4'b0100 : 4'b0000;
         #1;
         chk("hold_s", 32'(s), 32'h2);
         chk("hold_ack", 32'(ack), 32'h4);
         chk("hold_o", 32'(o), 32'hC);
         chk("hold_olast", 32'(o_last), (b == 2) ? 32'h1 : 32'h0);
         tick();
      end
      last = 4'b0000;
      #1;
      chk("hold_next_s", 32'(s), 32'h0);
      chk("hold_next_gnt", 32'(gnt), 32'h1);
      chk("hold_next_o", 32'(o), 32'hA);

      // ---- backpressure: owner 1 stalled by o_ready=0 for 20 cycles ----
      do_reset();
      req = 4'b0010; last = 4'b0010; o_ready = 1'b0;
      tick();
      for (int c = 0; c < 20; c++) begin
         chk("bp_gnt", 32'(gnt), 32'h2);
         chk("bp_ack", 32'(ack), 32'h0);
         chk("bp_ovalid", 32'(o_valid), 32'h1);
         chk("bp_cnt", 32'(dut.cnt_q), 32'h0);
         tick();
      end
      o_ready = 1'b1;
      #1;
      chk("bp_release_ack", 32'(ack), 32'h2);
      chk("bp_release_olast", 32'(o_last), 32'h1);
      tick();
      chk("bp_after_gnt", 32'(gnt), 32'h0);
      chk("bp_after_ovalid", 32'(o_valid), 32'h0);

      // ---- watchdog: owner 3 drops req mid-packet, requester 1 pending ----
      do_reset();
      req = 4'b1000; last = 4'b0000; o_ready = 1'b1;
      tick();
      chk("wd_beat1_ack", 32'(ack), 32'h8);
      tick();
      req = 4'b0010;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("wd_hold_gnt", 32'(gnt), 32'h8);
         chk("wd_hold_ack", 32'(ack), 32'h0);
         chk("wd_hold_ovalid", 32'(o_valid), 32'h0);
         tick();
      end
      chk("wd_new_gnt", 32'(gnt), 32'h2);
      chk("wd_new_s", 32'(s), 32'h1);
      chk("wd_new_ack", 32'(ack), 32'h2);

      // ---- lone requester: transfers on alternating cycles ----
      do_reset();
      req = 4'b0001; last = 4'b0001; o_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk("lone_ack", 32'(ack), (c % 2 == 1) ? 32'h1 : 32'h0);
         chk("lone_gnt", 32'(gnt), (c % 2 == 1) ? 32'h1 : 32'h0);
         tick();
      end

      // ---- reset during beat 2 of a 4-beat packet ----
      do_reset();
      req = 4'b0100; last = 4'b0000; o_ready = 1'b1;
      tick();
      chk("mr_beat1_ack", 32'(ack), 32'h4);
      tick();
      rst_n = 1'b0;
      #1;
      chk("mr_reset_ack", 32'(ack), 32'h0);
      tick();
      rst_n = 1'b1; req = 4'b1111; last = 4'b1111;
      #1;
      chk("mr_gnt", 32'(gnt), 32'h0);
      chk("mr_s", 32'(s), 32'h0);
      chk("mr_ovalid", 32'(o_valid), 32'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("mr_order_gnt", 32'(gnt), 32'(4'b0001 << i));
         chk("mr_order_s", 32'(s), 32'(i));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
